// File: rtl/vga_pkg.sv
// Shared widths, screen geometry, display modes and colour constants for the
// VGA sprite path.
package vga_pkg;
  localparam int X_W      = 10;
  localparam int Y_W      = 10;
  localparam int SPR_XW   = 10;
  localparam int SPR_YW   = 9;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_WIN    = 2'd1,
    MODE_LOSE   = 2'd2,
    MODE_BLANK  = 2'd3
  } mode_e;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
endpackage

// File: rtl/sprite_hit.sv
// One sprite channel: frame-stable shadow copy of position/enable/colour and
// the window test of the current pixel against it.
module sprite_hit
  import vga_pkg::*;
#(
  parameter int SPR_W = 10,
  parameter int SPR_H = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [SPR_XW-1:0] x_i,
  input  logic [SPR_YW-1:0] y_i,
  input  logic              en_i,
  input  logic [2:0]        rgb_i,
  input  logic [X_W-1:0]    x_count_i,
  input  logic [Y_W-1:0]    y_count_i,
  output logic              hit_o,
  output logic [2:0]        rgb_o
);
  logic [SPR_XW-1:0] sx_q;
  logic [SPR_YW-1:0] sy_q;
  logic              en_q;
  logic [2:0]        rgb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sx_q  <= '0;
      sy_q  <= '0;
      en_q  <= 1'b0;
      rgb_q <= '0;
    end else if (load_i) begin
      sx_q  <= x_i;
      sy_q  <= y_i;
      en_q  <= en_i;
      rgb_q <= rgb_i;
    end
  end

  // 11-bit window bounds: sprites near the right/bottom edge clip instead of wrapping.
  logic [10:0] px, py, sx, sy, x_end, y_end;
  assign px    = 11'(x_count_i);
  assign py    = 11'(y_count_i);
  assign sx    = 11'(sx_q);
  assign sy    = 11'(sy_q);
  assign x_end = sx + 11'(SPR_W);
  assign y_end = sy + 11'(SPR_H);

  assign hit_o = en_q && (px >= sx) && (px < x_end) && (py >= sy) && (py < y_end);
  assign rgb_o = rgb_q;
endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: per-frame shadow load, priority colour resolve
// with border and mode overrides, two-stage pipeline and per-frame collision flags.
module sprite_compositor
  import vga_pkg::*;
#(
  parameter int NUM_SPR  = 4,
  parameter int SPR_W    = 10,
  parameter int SPR_H    = 10,
  parameter int BORDER_W = 11
) (
  input  logic                      master_clk,
  input  logic                      resetn,
  input  logic                      pix_en,
  input  logic [X_W-1:0]            x_count,
  input  logic [Y_W-1:0]            y_count,
  input  logic                      display_area,
  input  logic [NUM_SPR*SPR_XW-1:0] spr_x,
  input  logic [NUM_SPR*SPR_YW-1:0] spr_y,
  input  logic [NUM_SPR-1:0]        spr_en,
  input  logic [NUM_SPR*3-1:0]      spr_rgb,
  input  logic                      pos_valid,
  input  logic [1:0]                mode,
  output logic                      pos_taken,
  output logic                      frame_done,
  output logic [NUM_SPR-1:0]        hit,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B
);
  logic fs, load;
  assign fs   = pix_en && (x_count == '0) && (y_count == '0);
  assign load = fs && pos_valid;

  logic [NUM_SPR-1:0] hit_c;
  logic [2:0]         rgb_c [NUM_SPR];

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
    sprite_hit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .clk_i     (master_clk),
      .rst_ni    (resetn),
      .load_i    (load),
      .x_i       (spr_x[g*SPR_XW +: SPR_XW]),
      .y_i       (spr_y[g*SPR_YW +: SPR_YW]),
      .en_i      (spr_en[g]),
      .rgb_i     (spr_rgb[g*3 +: 3]),
      .x_count_i (x_count),
      .y_count_i (y_count),
      .hit_o     (hit_c[g]),
      .rgb_o     (rgb_c[g])
    );
  end

  // Colour is captured alongside the hit bits so a shadow load never mixes
  // an old window with a new colour on the frame-start pixel.
  logic [2:0] sel_rgb_d;
  always_comb begin
    sel_rgb_d = BLACK;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_c[i]) sel_rgb_d = rgb_c[i];
    end
  end

  logic border_d;
  assign border_d = (int'(x_count) < BORDER_W) || (int'(x_count) >= H_ACTIVE - BORDER_W) ||
                    (int'(y_count) < BORDER_W) || (int'(y_count) >= V_ACTIVE - BORDER_W);

  logic [NUM_SPR-1:0] hit_s1_q;
  logic [2:0]         sel_rgb_s1_q;
  logic               border_s1_q, da_s1_q, fs_s1_q, pix_en_s1_q;
  mode_e              mode_s1_q;

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      hit_s1_q     <= '0;
      sel_rgb_s1_q <= BLACK;
      border_s1_q  <= 1'b0;
      da_s1_q      <= 1'b0;
      fs_s1_q      <= 1'b0;
      pix_en_s1_q  <= 1'b0;
      mode_s1_q    <= MODE_NORMAL;
    end else begin
      hit_s1_q     <= hit_c;
      sel_rgb_s1_q <= sel_rgb_d;
      border_s1_q  <= border_d;
      da_s1_q      <= display_area;
      fs_s1_q      <= fs;
      pix_en_s1_q  <= pix_en;
      mode_s1_q    <= mode_e'(mode);
    end
  end

  logic [2:0] col_d, col_q;
  always_comb begin
    col_d = BLACK;
    case (mode_s1_q)
      MODE_BLANK: col_d = BLACK;
      MODE_WIN:   col_d = GREEN;
      MODE_LOSE:  col_d = RED;
      default: begin
        if (!da_s1_q)         col_d = BLACK;
        else if (|hit_s1_q)   col_d = sel_rgb_s1_q;
        else if (border_s1_q) col_d = BLUE;
        else                  col_d = BLACK;
      end
    endcase
  end

  logic [NUM_SPR-1:0] contrib, hit_acc_d, hit_acc_q, hit_d, hit_q;
  logic               pos_taken_q;

  assign contrib = (pix_en_s1_q && da_s1_q && ($countones(hit_s1_q) > 1)) ? hit_s1_q : '0;

  // At frame start the in-flight contribution still belongs to the closing frame.
  always_comb begin
    hit_acc_d = hit_acc_q | contrib;
    hit_d     = hit_q;
    if (fs) begin
      hit_d     = hit_acc_q | contrib;
      hit_acc_d = '0;
    end
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      col_q       <= BLACK;
      hit_acc_q   <= '0;
      hit_q       <= '0;
      pos_taken_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      hit_acc_q   <= hit_acc_d;
      hit_q       <= hit_d;
      pos_taken_q <= load;
    end
  end

  assign pos_taken  = pos_taken_q;
  assign frame_done = fs_s1_q;
  assign hit        = hit_q;
  assign VGA_R      = {8{col_q[2]}};
  assign VGA_G      = {8{col_q[1]}};
  assign VGA_B      = {8{col_q[0]}};
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed plus randomized bench for sprite_compositor against a pixel-level model.
module tb_sprite_compositor;
  localparam int NS = 4;

  logic            master_clk = 1'b0;
  logic            resetn = 1'b0;
  logic            pix_en = 1'b0;
  logic [9:0]      x_count = '0;
  logic [9:0]      y_count = '0;
  logic            display_area = 1'b0;
  logic [NS*10-1:0] spr_x = '0;
  logic [NS*9-1:0] spr_y = '0;
  logic [NS-1:0]   spr_en = '0;
  logic [NS*3-1:0] spr_rgb = '0;
  logic            pos_valid = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            pos_taken, frame_done;
  logic [NS-1:0]   hit;
  logic [7:0]      VGA_R, VGA_G, VGA_B;

  sprite_compositor #(.NUM_SPR(NS), .SPR_W(10), .SPR_H(10), .BORDER_W(11)) dut (
    .master_clk(master_clk), .resetn(resetn), .pix_en(pix_en),
    .x_count(x_count), .y_count(y_count), .display_area(display_area),
    .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_rgb(spr_rgb),
    .pos_valid(pos_valid), .mode(mode), .pos_taken(pos_taken),
    .frame_done(frame_done), .hit(hit), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 master_clk = ~master_clk;

  int total = 0;
  int bad = 0;

  int live_x[NS], live_y[NS], live_en[NS], live_rgb[NS];
  int sh_x[NS], sh_y[NS], sh_en[NS], sh_rgb[NS];
  logic [NS-1:0] acc_m, hit_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] hits_at(input int x, input int y);
    logic [NS-1:0] m = '0;
    for (int i = 0; i < NS; i++)
      if (sh_en[i] != 0 && x >= sh_x[i] && x < sh_x[i] + 10 && y >= sh_y[i] && y < sh_y[i] + 10)
        m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] exp_col(input int x, input int y, input bit da, input int md);
    logic [NS-1:0] m;
    if (md == 3) return 3'b000;
    if (md == 1) return 3'b010;
    if (md == 2) return 3'b100;
    if (!da) return 3'b000;
    m = hits_at(x, y);
    for (int i = 0; i < NS; i++) if (m[i]) return 3'(sh_rgb[i]);
    if (x < 11 || x >= 629 || y < 11 || y >= 469) return 3'b001;
    return 3'b000;
  endfunction

  task automatic set_spr(input int i, input int x, input int y, input int en, input int rgb);
    live_x[i] = x; live_y[i] = y; live_en[i] = en; live_rgb[i] = rgb;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0; sh_rgb[i] = 0;
    end
    acc_m = '0;
    hit_m = '0;
  endtask

  task automatic pixel(input int x, input int y, input bit da, input int md, input bit pv);
    logic [2:0]    e;
    logic [NS-1:0] m, c;
    bit            fs, ept;
    @(posedge master_clk); #1;
    for (int i = 0; i < NS; i++) begin
      spr_x[i*10 +: 10] = 10'(live_x[i]);
      spr_y[i*9 +: 9]   = 9'(live_y[i]);
      spr_en[i]         = live_en[i][0];
      spr_rgb[i*3 +: 3] = 3'(live_rgb[i]);
    end
    x_count = 10'(x); y_count = 10'(y); display_area = da;
    mode = 2'(md); pos_valid = pv; pix_en = 1'b1;
    fs  = (x == 0 && y == 0);
    e   = exp_col(x, y, da, md);
    m   = hits_at(x, y);
    c   = (da && $countones(m) >= 2) ? m : '0;
    ept = fs && pv;
    if (fs) begin
      hit_m = acc_m;
      acc_m = c;
      if (pv) for (int i = 0; i < NS; i++) begin
        sh_x[i] = live_x[i]; sh_y[i] = live_y[i]; sh_en[i] = live_en[i]; sh_rgb[i] = live_rgb[i];
      end
    end else begin
      acc_m = acc_m | c;
    end
    @(posedge master_clk); #1;
    pix_en = 1'b0;
    chk("pos_taken", 32'(pos_taken), 32'(ept));
    chk("frame_done", 32'(frame_done), 32'(fs));
    chk("hit", 32'(hit), 32'(hit_m));
    @(posedge master_clk); #1;
    chk("pulse_end", 32'({pos_taken, frame_done}), 32'd0);
    chk("vga", 32'({VGA_R, VGA_G, VGA_B}), 32'({{8{e[2]}}, {8{e[1]}}, {8{e[0]}}}));
  endtask

  initial begin
    for (int i = 0; i < NS; i++) set_spr(i, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge master_clk);
    #1;
    chk("reset_vga", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    chk("reset_flags", 32'({pos_taken, frame_done, hit}), 32'd0);
    resetn = 1'b1;

    // single sprite, shadow load, border
    set_spr(0, 100, 50, 1, 3'b100);
    pixel(0, 0, 1, 0, 1);
    pixel(100, 50, 1, 0, 0);
    chk("red_pix", 32'(VGA_R), 32'hFF);
    pixel(110, 50, 1, 0, 0);
    pixel(109, 59, 1, 0, 0);
    pixel(5, 200, 1, 0, 0);
    chk("border_blue", 32'(VGA_B), 32'hFF);
    pixel(100, 50, 0, 0, 0);

    // overlap and collision flags
    set_spr(0, 295, 195, 1, 3'b100);
    set_spr(1, 300, 200, 1, 3'b010);
    pixel(0, 0, 1, 0, 1);
    pixel(300, 200, 1, 0, 0);
    pixel(296, 196, 1, 0, 0);
    pixel(305, 205, 1, 0, 0);
    pixel(0, 0, 1, 0, 0);
    chk("hit_overlap", 32'(hit), 32'h3);
    pixel(296, 196, 1, 0, 0);
    pixel(0, 0, 1, 0, 0);
    chk("hit_clear", 32'(hit), 32'h0);

    // edge clipping
    set_spr(1, 0, 0, 0, 0);
    set_spr(0, 635, 100, 1, 3'b110);
    set_spr(2, 300, 475, 1, 3'b011);
    pixel(0, 0, 1, 0, 1);
    for (int x = 633; x < 640; x++) pixel(x, 100, 1, 0, 0);
    for (int x = 0; x < 5; x++) pixel(x, 100, 1, 0, 0);
    for (int y = 473; y < 480; y++) pixel(302, y, 1, 0, 0);
    for (int y = 0; y < 5; y++) pixel(302, y + 1, 1, 0, 0);

    // mid-frame change held until fs, then hold with pos_valid low
    set_spr(0, 200, 100, 1, 3'b100);
    set_spr(2, 0, 0, 0, 0);
    pixel(0, 0, 1, 0, 1);
    set_spr(0, 400, 300, 1, 3'b100);
    pixel(200, 100, 1, 0, 1);
    pixel(400, 300, 1, 0, 1);
    pixel(0, 0, 1, 0, 1);
    pixel(400, 300, 1, 0, 0);
    pixel(200, 100, 1, 0, 0);
    set_spr(0, 50, 50, 1, 3'b100);
    pixel(0, 0, 1, 0, 0);
    pixel(400, 300, 1, 0, 0);
    pixel(50, 50, 1, 0, 0);

    // modes with overlaps still accounted
    set_spr(0, 100, 100, 1, 3'b100);
    set_spr(1, 105, 105, 1, 3'b001);
    pixel(0, 0, 1, 1, 1);
    pixel(106, 106, 1, 1, 0);
    pixel(700, 500, 0, 1, 0);
    pixel(0, 0, 1, 1, 0);
    chk("hit_in_win", 32'(hit), 32'h3);
    pixel(106, 106, 1, 3, 0);
    pixel(10, 10, 1, 3, 0);
    pixel(106, 106, 1, 2, 0);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NS; i++)
        set_spr(i, $urandom_range(0, 120), $urandom_range(0, 90), int'($urandom_range(0, 4) != 0), $urandom_range(0, 7));
      pixel(0, 0, 1, 0, 1);
      for (int k = 0; k < 30; k++) begin
        int s = $urandom_range(0, NS - 1);
        pixel(live_x[s] + $urandom_range(0, 13) - 2 < 0 ? 1 : live_x[s] + $urandom_range(0, 13) - 2,
              live_y[s] + $urandom_range(0, 12) + 1,
              $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0 ? $urandom_range(0, 3) : 0, 0);
      end
    end
    pixel(0, 0, 1, 0, 0);

    // asynchronous mid-frame reset
    set_spr(0, 100, 100, 1, 3'b100);
    set_spr(1, 105, 105, 1, 3'b010);
    pixel(0, 0, 1, 0, 1);
    pixel(106, 106, 1, 1, 0);
    @(posedge master_clk); #3;
    resetn = 1'b0;
    #1;
    chk("async_vga", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
    chk("async_flags", 32'({pos_taken, frame_done, hit}), 32'd0);
    repeat (3) @(posedge master_clk);
    #1;
    resetn = 1'b1;
    model_reset();
    pixel(106, 106, 1, 0, 0);
    pixel(0, 0, 1, 0, 0);
    chk("hit_after_reset", 32'(hit), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-channel sprite renderer for the 640x480 VGA path. It takes pixel coordinates from the timing generator and per-sprite positions from the processor-side registers. Positions are captured into shadow registers once per frame, so objects never tear mid-frame. Each pixel's colour comes from priority-resolved sprites, a border and full-screen mode overrides, and per-sprite collision flags are reported once per frame. It replaces the fixed player/enemy/bullet drawing logic and the free-running position update clock.

## Interface
Parameters:
- NUM_SPR, 4: number of sprite channels (2..8); channel 0 has highest priority.
- SPR_W, 10: sprite width in pixels (1..63).
- SPR_H, 10: sprite height in pixels (1..63).
- BORDER_W, 11: border thickness in pixels; 0 disables the border.

Ports:
- master_clk  in  1  system clock (50 MHz); the only clock.
- resetn  in  1  asynchronous, active-low reset.
- pix_en  in  1  one-cycle strobe per pixel (25 MHz rate).
- x_count  in  10  current pixel column.
- y_count  in  10  current pixel row.
- display_area  in  1  high inside the active 640x480 region.
- spr_x  in  NUM_SPR*10  packed sprite left edges; channel i occupies bits [i*10+:10].
- spr_y  in  NUM_SPR*9  packed sprite top edges.
- spr_en  in  NUM_SPR  per-sprite visible enable.
- spr_rgb  in  NUM_SPR*3  per-sprite colour, {R,G,B} one bit each.
- pos_valid  in  1  new position set is ready on the spr_* inputs.
- mode  in  2  display mode: 0 normal, 1 win (green fill), 2 lose (red fill), 3 blank.
- pos_taken  out  1  one-cycle pulse when the shadow registers load.
- frame_done  out  1  one-cycle pulse when `hit` updates.
- hit  out  NUM_SPR  hit[i] is set if sprite i overlapped any other enabled sprite during the previous frame.
- VGA_R, VGA_G, VGA_B  out  8  each colour bit replicated 8 times.

## Operation
- Frame start (`fs`) is defined as: pix_en high and x_count == 0 and y_count == 0.
- Shadow load:
  - On fs with pos_valid high, spr_x, spr_y, spr_en and spr_rgb load into the shadow registers and pos_taken pulses.
  - On fs with pos_valid low, the shadow registers hold and pos_taken stays low.
  - No load occurs at any other time.
- Hit test for channel i:
  - Condition: shadow enable set, and x_count >= sx, and x_count < sx+SPR_W, and y_count >= sy, and y_count < sy+SPR_H.
  - Sums are computed at 11 bits so they do not wrap. A sprite near the right or bottom edge is clipped, never wrapped to column or row 0.
- Colour priority, highest first:
  1. mode 3: black.
  2. mode 1: {0,1,0} on every pixel.
  3. mode 2: {1,0,0} on every pixel.
  4. display_area low: black.
  5. Lowest-index hitting sprite: its shadow rgb.
  6. Border pixel: {0,0,1}.
  7. Otherwise: black.
- Border pixel definition: x_count < BORDER_W, or x_count >= 640-BORDER_W, or y_count < BORDER_W, or y_count >= 480-BORDER_W.
- Collision accumulation:
  - On each pix_en with display_area high where two or more channels hit, every hitting channel's bit in hit_acc sets.
  - On fs, hit <= hit_acc and frame_done pulses. hit_acc then restarts from only the contribution of the fs pixel, so no event is lost.
  - A mode change does not affect collision accounting.
- Reset mid-frame: all state clears immediately. The next fs behaves as the first frame after reset, so hit becomes all-zero unless overlaps occur.

## Timing
- Reset values:
  - Shadow registers, hit_acc, hit, pos_taken, frame_done and the VGA_* outputs are 0.
  - Pipeline registers are 0.
- Pipeline: two stages, free-running on every master_clk cycle and not gated by pix_en.
  - Stage 1 registers the per-channel hit bits, the border bit, display_area, mode and the fs flag.
  - Stage 2 registers the resolved colour into VGA_*.
  - Latency from coordinates to VGA_* is exactly 2 master_clk cycles.
- Shadow load, pos_taken, hit update and frame_done all occur at the clock edge that samples fs.
  - pos_taken and frame_done go high on the cycle after that edge, for one cycle.
  - The new shadow values affect colour from the following pixel onward.
- Collision flags are set from stage-1 hit bits. A pix_en sampled at cycle t contributes to hit_acc at edge t+1.

## Structure
- Package vga_pkg holds:
  - Coordinate widths (X_W=10, Y_W=10, SPR_XW=10, SPR_YW=9) and H_ACTIVE=640, V_ACTIVE=480.
  - Mode encodings MODE_NORMAL, MODE_WIN, MODE_LOSE, MODE_BLANK.
  - 3-bit colour constants BLACK, RED, GREEN, BLUE.
- Sub-module sprite_hit is instanced once per channel with a generate loop. It holds one channel's shadow registers and performs the 11-bit window compare.

## Test plan
- Reset, then NUM_SPR=4, sprite 0 at (100,50), en=1, rgb=3'b100, pos_valid=1 through one fs -> pos_taken pulses once. Pixel (100,50) gives VGA_R=8'hFF, G=B=0 two cycles after it is presented. Pixel (110,50) gives black. Pixel (5,200) gives blue (border).
- Sprites 0 and 1 both covering (300,200), rgb 3'b100 and 3'b010 -> pixel (300,200) is red. Next fs gives hit=4'b0011 and a frame_done pulse. A frame without overlap gives hit=0 at the following fs.
- Sprite at x=635 -> columns 635..639 are drawn, columns 0..4 are not. Sprite at y=475 is clipped likewise.
- Change spr_x mid-frame with pos_valid=1 -> drawing is unchanged until fs, then the new position appears. With pos_valid=0 at fs -> the old position is held and pos_taken stays low.
- mode=1 during a frame with overlaps -> every pixel, including blanking, is green. hit is still updated at fs. mode=3 -> all outputs 0.
- Assert resetn low mid-frame for 3 cycles -> all outputs are 0 asynchronously and hit=0 at the next fs.
